// File: rtl/ether_pkg.sv
// ============================================================================
// ether_pkg : shared types and constants for the RMII receive frame sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package ether_pkg;

  localparam int DATA_W_DEFAULT = 2401;
  localparam int MAX_BYTES      = 300;
  localparam int SLOT_BITS      = 8 * MAX_BYTES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1
  } state_t;

  // A slot only ever holds an accepted frame, so MAX_BYTES of data is enough.
  typedef struct packed {
    logic [SLOT_BITS-1:0] data;
    logic [15:0]          len;
    logic                 valid;
  } frame_slot_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : synchronous counter with clear that sticks at all-ones
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ether_rx_frame_sequencer.sv
// ============================================================================
// ether_rx_frame_sequencer : two-slot frame buffer serialised to AXI-Stream
// Revision                 : 1.0
// ============================================================================
`default_nettype none

module ether_rx_frame_sequencer #(
  parameter int DATA_W    = ether_pkg::DATA_W_DEFAULT,
  parameter int MAX_BYTES = ether_pkg::MAX_BYTES,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] s00_frame_data,
  input  logic              s00_frame_valid,
  input  logic [15:0]       s00_frame_len,
  output logic [7:0]        m00_axis_tdata,
  output logic              m00_axis_tvalid,
  input  logic              m00_axis_tready,
  output logic              m00_axis_tlast,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  reject_count,
  output logic [31:0]       debug
);

  import ether_pkg::*;

  state_t              state_q, state_d;
  frame_slot_t         act_q, act_d;
  frame_slot_t         pend_q, pend_d;
  logic [8:0]          idx_q, idx_d;
  logic [SLOT_BITS-1:0] in_data;
  frame_slot_t         incoming;
  logic                len_bad, capture, good, xfer, last_xfer;
  logic                drop_inc, reject_inc;
  logic                unused_slot_bits;

  generate
    if (DATA_W > SLOT_BITS) begin : g_trunc
      logic unused_hi_bits;
      assign unused_hi_bits = ^s00_frame_data[DATA_W-1:SLOT_BITS];
      assign in_data        = s00_frame_data[SLOT_BITS-1:0];
    end else begin : g_fit
      assign in_data = SLOT_BITS'(s00_frame_data);
    end
  endgenerate

  assign incoming = '{data: in_data, len: s00_frame_len, valid: 1'b1};

  // Length is judged at full width so that e.g. 16'h0201 is not mistaken for 1.
  assign len_bad    = (s00_frame_len == 16'd0) || (s00_frame_len > 16'(MAX_BYTES));
  assign capture    = s00_frame_valid && enable;
  assign good       = capture && !len_bad;
  assign reject_inc = capture && len_bad;
  assign xfer       = (state_q == STREAM) && m00_axis_tready;
  assign last_xfer  = xfer && (idx_q == 9'd0);

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    pend_d   = pend_q;
    idx_d    = idx_q;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (good) begin
          act_d   = incoming;
          idx_d   = s00_frame_len[8:0] - 9'd1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          // Promotion happens before capture, so a full pending slot frees up in time.
          if (pend_q.valid) begin
            act_d        = pend_q;
            idx_d        = pend_q.len[8:0] - 9'd1;
            pend_d.valid = 1'b0;
            if (good) pend_d = incoming;
          end else if (good) begin
            act_d = incoming;
            idx_d = s00_frame_len[8:0] - 9'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) idx_d = idx_q - 9'd1;
          if (good) begin
            if (!pend_q.valid) pend_d = incoming;
            else               drop_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 9'd0;
      act_q.valid  <= 1'b0;
      pend_q.valid <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_drop_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (drop_inc),
    .count (drop_count)
  );

  sat_counter #(.W(CNT_W)) u_reject_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (reject_inc),
    .count (reject_count)
  );

  assign m00_axis_tvalid = (state_q == STREAM);
  assign m00_axis_tdata  = (state_q == STREAM) ? act_q.data[8*idx_q +: 8] : 8'h00;
  assign m00_axis_tlast  = (state_q == STREAM) && (idx_q == 9'd0);
  assign busy            = (state_q == STREAM) || pend_q.valid;

  // The listed fields total 34 bits; padding is narrowed to 4 so every field fits in 32.
  assign debug = {drop_count[7:0], reject_count[7:0], 4'b0, pend_q.valid, state_q, idx_q};

  assign unused_slot_bits = ^{act_q.len, act_q.valid, pend_q.len[15:9]};

endmodule

`default_nettype wire

// File: tb/tb_ether_rx_frame_sequencer.sv
// ============================================================================
// tb_ether_rx_frame_sequencer : directed + random bench with a byte-queue model
// Revision                    : 1.0
// ============================================================================
`default_nettype none

module tb_ether_rx_frame_sequencer;

  localparam int DW = 2401;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic [DW-1:0] fdata = '0;
  logic          fvalid = 1'b0;
  logic [15:0]   flen = 16'd0;
  logic [7:0]    tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic          busy;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] reject_count;
  logic [31:0]   debug;

  ether_rx_frame_sequencer #(.DATA_W(DW), .MAX_BYTES(300), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .s00_frame_data  (fdata),
    .s00_frame_valid (fvalid),
    .s00_frame_len   (flen),
    .m00_axis_tdata  (tdata),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tready (tready),
    .m00_axis_tlast  (tlast),
    .busy            (busy),
    .drop_count      (drop_count),
    .reject_count    (reject_count),
    .debug           (debug)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: every byte still owed downstream, in order, plus outstanding frame count.
  logic [7:0] exp_q[$];
  bit         last_q[$];
  int         nfr = 0;
  int         m_drop = 0;
  int         m_rej = 0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_q.delete();
      nfr = 0;
      m_drop = 0;
      m_rej = 0;
    end else begin
      if (nfr > 0 && tready) begin
        if (last_q[0]) nfr--;
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      if (fvalid && enable) begin
        if (flen == 16'd0 || flen > 16'd300) begin
          if (m_rej < 65535) m_rej++;
        end else if (nfr == 2) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          for (int i = 0; i < int'(flen); i++) begin
            exp_q.push_back(fdata[8*(int'(flen)-1-i) +: 8]);
            last_q.push_back(i == int'(flen) - 1);
          end
          nfr++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_tvalid", {31'd0, tvalid}, {31'd0, nfr > 0});
    chk("m_busy", {31'd0, busy}, {31'd0, nfr > 0});
    chk("m_drop_count", 32'(drop_count), 32'(m_drop));
    chk("m_reject_count", 32'(reject_count), 32'(m_rej));
    if (nfr > 0) begin
      chk("m_tdata", 32'(tdata), 32'(exp_q[0]));
      chk("m_tlast", {31'd0, tlast}, {31'd0, last_q[0]});
    end
  end

  function automatic logic [DW-1:0] rnd_frame(input int len);
    logic [DW-1:0] d = '0;
    for (int i = 0; i < len; i++) d[8*i +: 8] = 8'($urandom);
    return d;
  endfunction

  // Called just after a negedge; returns one negedge later with valid dropped.
  task automatic send(input int len, input logic [DW-1:0] d);
    fvalid = 1'b1;
    flen   = 16'(len);
    fdata  = d;
    @(negedge clk);
    fvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic [7:0]    seq[4];
    int            beats, lastpos, len, r;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, tlast}, 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_reject", 32'(reject_count), 32'd0);

    // single 3-byte frame, no backpressure
    tready = 1'b1;
    d = '0; d[23:0] = 24'hA1B2C3;
    send(3, d);
    chk("t1_b0", 32'(tdata), 32'hA1);
    chk("t1_b0_last", {31'd0, tlast}, 32'd0);
    @(negedge clk); chk("t1_b1", 32'(tdata), 32'hB2);
    @(negedge clk); chk("t1_b2", 32'(tdata), 32'hC3);
    chk("t1_b2_last", {31'd0, tlast}, 32'd1);
    @(negedge clk); chk("t1_idle", {31'd0, tvalid}, 32'd0);

    // backpressure after the first beat
    send(3, d);
    chk("t2_b0", 32'(tdata), 32'hA1);
    @(negedge clk);
    tready = 1'b0;
    chk("t2_b1", 32'(tdata), 32'hB2);
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_valid", {31'd0, tvalid}, 32'd1);
      chk("t2_hold_data", 32'(tdata), 32'hB2);
    end
    tready = 1'b1;
    @(negedge clk); chk("t2_b2", 32'(tdata), 32'hC3);
    @(negedge clk); chk("t2_idle", {31'd0, tvalid}, 32'd0);

    // three frames back to back while stalled: third dropped
    tready = 1'b0;
    d = '0; d[15:0] = 16'h1112; send(2, d);
    d = '0; d[15:0] = 16'h2122; send(2, d);
    d = '0; d[15:0] = 16'h3132; send(2, d);
    chk("t3_drop", 32'(drop_count), 32'd1);
    tready = 1'b1;
    seq = '{8'h11, 8'h12, 8'h21, 8'h22};
    for (int k = 0; k < 4; k++) begin
      chk("t3_valid", {31'd0, tvalid}, 32'd1);
      chk("t3_data", 32'(tdata), 32'(seq[k]));
      chk("t3_last", {31'd0, tlast}, {31'd0, (k == 1) || (k == 3)});
      @(negedge clk);
    end
    chk("t3_idle", {31'd0, tvalid}, 32'd0);

    // capture coincides with the last transfer while pending is full
    tready = 1'b0;
    d = '0; d[15:0] = 16'h4142; send(2, d);
    d = '0; d[15:0] = 16'h5152; send(2, d);
    tready = 1'b1;
    chk("t4_a0", 32'(tdata), 32'h41);
    @(negedge clk);
    chk("t4_a1_last", {31'd0, tlast}, 32'd1);
    d = '0; d[15:0] = 16'h6162; send(2, d);
    seq = '{8'h51, 8'h52, 8'h61, 8'h62};
    for (int k = 0; k < 4; k++) begin
      chk("t4_data", 32'(tdata), 32'(seq[k]));
      @(negedge clk);
    end
    chk("t4_idle", {31'd0, tvalid}, 32'd0);
    chk("t4_drop", 32'(drop_count), 32'd1);

    // length boundaries
    send(0, rnd_frame(4));
    send(301, rnd_frame(300));
    chk("t5_no_out", {31'd0, tvalid}, 32'd0);
    chk("t5_reject", 32'(reject_count), 32'd2);
    d = rnd_frame(300);
    send(300, d);
    chk("t5_first", 32'(tdata), 32'(d[2399:2392]));
    beats = 0; lastpos = 0;
    while (tvalid === 1'b1 && beats < 400) begin
      beats++;
      if (tlast) lastpos = beats;
      @(negedge clk);
    end
    chk("t5_beats", 32'(beats), 32'd300);
    chk("t5_lastpos", 32'(lastpos), 32'd300);

    // reset in the middle of a frame
    d = rnd_frame(10);
    send(10, d);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_tvalid", {31'd0, tvalid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_drop", 32'(drop_count), 32'd0);
    chk("t6_reject", 32'(reject_count), 32'd0);
    rst = 1'b0;
    d = '0; d[23:0] = 24'hD1D2D3;
    send(3, d);
    chk("t6_b0", 32'(tdata), 32'hD1);
    @(negedge clk); chk("t6_b1", 32'(tdata), 32'hD2);
    @(negedge clk); chk("t6_b2", 32'(tdata), 32'hD3);
    chk("t6_b2_last", {31'd0, tlast}, 32'd1);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      enable = ($urandom % 8) != 0;
      tready = ($urandom % 4) != 0;
      rst    = ($urandom % 700) == 0;
      if ($urandom % 5 == 0) begin
        r = int'($urandom % 16);
        len = (r == 0) ? 0 : (r == 1) ? 301 : (r == 2) ? 300 : (r == 3) ? 1
            : 1 + int'($urandom % 24);
        fvalid = 1'b1;
        flen   = 16'(len);
        fdata  = rnd_frame(len > 300 ? 300 : len);
      end else begin
        fvalid = 1'b0;
      end
      @(negedge clk);
    end
    fvalid = 1'b0; rst = 1'b0; enable = 1'b1; tready = 1'b1;
    repeat (700) @(negedge clk);
    chk("drain_idle", {31'd0, tvalid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
